modmul_arbiter: RTL
===================

Name: modmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one variable-latency 255-bit modular multiplier (mod p = 2^255-19) between N_REQ requesters.
- Typical requesters: point-add/double datapaths and the final z-inversion unit.
- Accepts one request at a time, issues a start pulse with registered operands, waits for the multiplier's finished pulse, then routes the product back to the winning requester with a one-cycle done pulse.
- Sits between the ECC datapath blocks and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 255, operand/result width in bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req  input  N_REQ  per-requester request level.
- i_a  input  N_REQ*W  operand A; requester k occupies bits [k*W +: W].
- i_b  input  N_REQ*W  operand B, same packing as i_a.
- o_gnt  output  N_REQ  one-hot, one-cycle pulse: request accepted, operands captured.
- o_done  output  N_REQ  one-hot, one-cycle pulse: o_result valid for that requester.
- o_result  output  W  last product; held until the next RESP.
- o_busy  output  1  high in ISSUE, WAIT and RESP.
- o_mul_start  output  1  one-cycle start pulse to the multiplier.
- o_mul_a  output  W  registered operand A, stable from ISSUE through WAIT.
- o_mul_b  output  W  registered operand B, stable from ISSUE through WAIT.
- i_mul_result  input  W  multiplier product.
- i_mul_finished  input  1  one-cycle multiplier completion pulse.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values: every output is 0; state = IDLE; rr_ptr = 0; idx_r = 0.
- IDLE:
  - If any i_req is high, the winner is the requester k with the smallest (k - rr_ptr) mod N_REQ.
  - Latch idx_r = k, o_mul_a = i_a[k], o_mul_b = i_b[k]; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): o_mul_start = 1 and o_gnt[idx_r] = 1; go to WAIT.
- WAIT:
  - On i_mul_finished: latch o_result = i_mul_result; go to RESP.
  - Otherwise stay in WAIT; there is no timeout.
- RESP (exactly 1 cycle): o_done[idx_r] = 1; rr_ptr = (idx_r + 1) mod N_REQ; go to IDLE.
- Latency: request sampled at cycle 0 → start/gnt at cycle 1 → finished at cycle 1+L → done at cycle 2+L. Back-to-back requests issue every L+3 cycles.
- Requester rules:
  - Hold i_req and its operands stable until o_gnt is seen.
  - Deassert i_req in the cycle after o_gnt unless it wants a new operation.
  - i_req still high when the FSM returns to IDLE counts as a new request.
  - Dropping i_req before o_gnt withdraws the request with no side effects.
- Operand changes after the IDLE capture have no effect on the operation in flight.
- i_mul_finished in IDLE, ISSUE or RESP is ignored: no done pulse, o_result unchanged.
- At most one bit of o_gnt and one bit of o_done is high in any cycle; the two are never high in the same cycle.
- Reset asserted mid-operation clears all state and outputs immediately, with no clock edge needed. The multiplier shares i_rst, so no stale finished pulse is expected.
- o_result is passed through unmodified; the arbiter performs no arithmetic.

Decomposition:
- Shared package ecc_pkg:
  - W_FIELD = 255.
  - Constant P = 2^255-19.
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_pick: combinational rotate-priority-rotate over N_REQ bits. Inputs are the request vector and rr_ptr; outputs are a one-hot winner and its index.

Test Plan:
- Single request: only req[2], a=3, b=5; multiplier model with L=4 → gnt[2] and start at cycle 1, done[2] at cycle 6, o_result=15, o_busy low at cycle 7.
- Fairness from reset: all four requests held continuously → grant order 0,1,2,3,0; each issue L+3=7 cycles after the previous one.
- Pointer rotation: after req[1] is served (rr_ptr=2), assert req[0] and req[3] together → req[3] is granted first, then req[0].
- Boundary operands: a = b = P-1 (2^255-20) on req[1] → o_result=1, done on bit 1 only, o_mul_a/o_mul_b equal P-1 throughout WAIT.
- Spurious finished: pulse i_mul_finished in IDLE, and again in WAIT after the real finished → no extra done pulse, o_result unchanged.
- Reset mid-operation: assert i_rst asynchronously in WAIT → all outputs 0 before the next clock edge. After release, simultaneous req[3] and req[0] → req[0] is granted first.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC field-arithmetic blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ecc_pkg;

   localparam int W_FIELD = 255;

   // Field modulus 2^255 - 19
   localparam logic [W_FIELD-1:0] P = W_FIELD'((256'd1 << 255) - 256'd19);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/modmul_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so rr_ptr sits at bit 0, take lowest set bit, rotate back.
// Latency: purely combinational.
// Backpressure: none; o_vld is low when no request is pending.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_vld,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx
);

   localparam logic [IW:0] N_EXT = (IW+1)'(N);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [IW-1:0]  w_off;
   logic [IW:0]    w_raw;
   logic [IW:0]    w_sum;

   // Doubling the vector turns the right shift into a rotation.
   assign w_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot = w_dbl[N-1:0];

   // Lowest set bit of the rotated vector is the winner's distance from the pointer.
   always_comb begin
      w_off = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off = IW'(j);
         end
      end
   end

   // Add the pointer back, wrapping modulo N.
   assign w_raw    = {1'b0, w_off} + {1'b0, i_ptr};
   assign w_sum    = (w_raw >= N_EXT) ? (w_raw - N_EXT) : w_raw;
   assign o_idx    = w_sum[IW-1:0];
   assign o_vld    = |i_req;
   assign o_onehot = o_vld ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin sequencer sharing one variable-latency modular multiplier between N_REQ requesters.
// Latency: start/gnt 1 cycle after the request is sampled, done 1 cycle after the multiplier finishes.
// Backpressure: one operation in flight; requesters hold i_req and operands until o_gnt.
module modmul_arbiter
   import ecc_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = W_FIELD
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [N_REQ*W-1:0] i_a,
   input  logic [N_REQ*W-1:0] i_b,
   output logic [N_REQ-1:0]   o_gnt,
   output logic [N_REQ-1:0]   o_done,
   output logic [W-1:0]       o_result,
   output logic               o_busy,
   output logic               o_mul_start,
   output logic [W-1:0]       o_mul_a,
   output logic [W-1:0]       o_mul_b,
   input  logic [W-1:0]       i_mul_result,
   input  logic               i_mul_finished
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_ptr;
   logic [W-1:0]     r_mul_a;
   logic [W-1:0]     r_mul_b;
   logic [W-1:0]     r_result;
   logic             w_pick_vld;
   logic [N_REQ-1:0] w_pick_oh;
   logic [IW-1:0]    w_pick_idx;
   logic [W-1:0]     w_sel_a;
   logic [W-1:0]     w_sel_b;
   logic [N_REQ-1:0] w_idx_oh;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_vld    (w_pick_vld),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx)
   );

   // One-hot AND-OR select of the winner's operands.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sel_a = w_sel_a | (i_a[k*W +: W] & {W{w_pick_oh[k]}});
         w_sel_b = w_sel_b | (i_b[k*W +: W] & {W{w_pick_oh[k]}});
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and pulse outputs; finished outside WAIT is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_oh    = N_REQ'(1) << r_idx;
      o_gnt       = '0;
      o_done      = '0;
      o_mul_start = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (w_pick_vld) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            o_mul_start = 1'b1;
            o_gnt       = w_idx_oh;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (i_mul_finished) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            o_done      = w_idx_oh;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Winner/operand capture in IDLE, product capture in WAIT, pointer advance in RESP.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx    <= '0;
         r_ptr    <= '0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
         r_result <= '0;
      end else begin
         if (r_state == IDLE && w_pick_vld) begin
            r_idx   <= w_pick_idx;
            r_mul_a <= w_sel_a;
            r_mul_b <= w_sel_b;
         end
         if (r_state == WAIT && i_mul_finished) begin
            r_result <= i_mul_result;
         end
         if (r_state == RESP) begin
            r_ptr <= (r_idx == IW'(N_REQ - 1)) ? '0 : (r_idx + IW'(1));
         end
      end
   end

   assign o_mul_a  = r_mul_a;
   assign o_mul_b  = r_mul_b;
   assign o_result = r_result;

endmodule
